// File: rtl/game_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_ctrl_if
//
// Bundles the player/playfield signals of the snake-style game controller.
//
//   master modport : game side (buttons, collision detector, food logic).
//                    Drives direction requests, pause, collision flags and
//                    the food pulse; observes the controller outputs.
//   slave modport  : the controller (game_ctrl).
//
//   up/down/left/right : level-sensitive direction requests
//   pause              : level pause button (controller edge-detects it)
//   hit_boundary       : snake head left the playfield
//   hit_self           : snake head ran into its own body
//   food_eaten         : one-cycle pulse when food is consumed
//   game_state         : RUNNING=0, DIE=1, INITIAL=2, PAUSED=3, GAME_OVER=4
//   lives_left         : remaining lives
//   score              : food eaten this game, saturating
//   level              : difficulty level, saturating
//   move_tick          : one-cycle pulse telling the snake to advance
// ---------------------------------------------------------------------------
interface game_ctrl_if #(
    parameter int unsigned SCORE_W = 16
);
    logic               up;
    logic               down;
    logic               left;
    logic               right;
    logic               pause;
    logic               hit_boundary;
    logic               hit_self;
    logic               food_eaten;
    logic [2:0]         game_state;
    logic [3:0]         lives_left;
    logic [SCORE_W-1:0] score;
    logic [2:0]         level;
    logic               move_tick;

    modport master (
        output up, down, left, right, pause,
        output hit_boundary, hit_self, food_eaten,
        input  game_state, lives_left, score, level, move_tick
    );

    modport slave (
        input  up, down, left, right, pause,
        input  hit_boundary, hit_self, food_eaten,
        output game_state, lives_left, score, level, move_tick
    );
endinterface

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
//
// Top-level game state machine for a snake-style game. Tracks the game phase,
// lives, score and level, and generates the move_tick pulse whose period
// shrinks as the level rises.
//
// Ports:
//   clk : system clock, the only clock
//   rst : synchronous, active-high reset (priority over every other input)
//   gc  : game_ctrl_if.slave -- direction/pause/collision/food inputs and
//         game_state/lives_left/score/level/move_tick outputs
//
// Parameters:
//   DIE_CYCLES     : cycles spent in DIE after a collision (>= 1)
//   LIVES          : lives per game (1..15)
//   SCORE_W        : score width (must match the interface SCORE_W)
//   BASE_PERIOD    : move_tick period at level 0
//   PERIOD_STEP    : period reduction per level
//   MIN_PERIOD     : period floor
//   FOOD_PER_LEVEL : food pulses needed to advance one level
//   MAX_LEVEL      : highest level (fits 3 bits)
// ---------------------------------------------------------------------------
module game_ctrl #(
    parameter int unsigned DIE_CYCLES     = 100_000_000,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned SCORE_W        = 16,
    parameter int unsigned BASE_PERIOD    = 25_000_000,
    parameter int unsigned PERIOD_STEP    = 2_500_000,
    parameter int unsigned MIN_PERIOD     = 5_000_000,
    parameter int unsigned FOOD_PER_LEVEL = 5,
    parameter int unsigned MAX_LEVEL      = 7
) (
    input  logic         clk,
    input  logic         rst,
    game_ctrl_if.slave   gc
);

    typedef enum logic [2:0] {
        ST_RUNNING   = 3'd0,
        ST_DIE       = 3'd1,
        ST_INITIAL   = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
    localparam logic [2:0]         MAX_LVL    = 3'(MAX_LEVEL);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE  = {{(SCORE_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]        DIE_LAST   = 32'(DIE_CYCLES - 1);
    localparam logic [31:0]        FOOD_LVL   = 32'(FOOD_PER_LEVEL);
    localparam logic [31:0]        BASE_P     = 32'(BASE_PERIOD);
    localparam logic [31:0]        STEP_P     = 32'(PERIOD_STEP);
    // A zero floor would make the tick counter's terminal value wrap to
    // all-ones; clamp it so the shortest period is one cycle.
    localparam logic [31:0]        FLOOR_P    = (MIN_PERIOD == 0) ? 32'd1 : 32'(MIN_PERIOD);

    // Register declarations carry their reset values as initialisers so the
    // FPGA configuration state matches the post-reset state.
    state_t             state_reg      = ST_INITIAL;
    state_t             state_next;
    logic [3:0]         lives_reg      = LIVES_INIT;
    logic [3:0]         lives_next;
    logic [SCORE_W-1:0] score_reg      = '0;
    logic [SCORE_W-1:0] score_next;
    logic [2:0]         level_reg      = '0;
    logic [2:0]         level_next;
    logic [31:0]        food_cnt_reg   = '0;
    logic [31:0]        food_cnt_next;
    logic [31:0]        tick_cnt_reg   = '0;
    logic [31:0]        tick_cnt_next;
    logic [31:0]        die_cnt_reg    = '0;
    logic [31:0]        die_cnt_next;
    logic               pause_prev_reg = 1'b0;

    logic        any_dir;
    logic        hit;
    logic        pause_rise;
    logic [31:0] step_total;
    logic [31:0] period;
    logic [31:0] tick_last;
    logic        tick_now;

    assign any_dir    = gc.up | gc.down | gc.left | gc.right;
    assign hit        = gc.hit_boundary | gc.hit_self;
    assign pause_rise = gc.pause & ~pause_prev_reg;

    // Tick period for the current level. The subtraction is only taken when
    // it stays above the floor, so it can never underflow.
    always_comb begin
        step_total = 32'(level_reg) * STEP_P;
        period     = FLOOR_P;
        if ((BASE_P > step_total) && ((BASE_P - step_total) > FLOOR_P)) begin
            period = BASE_P - step_total;
        end
        tick_last = period - 32'd1;
    end

    // ">=" rather than "==": after a level-up shortens the period the counter
    // may already sit past the new terminal value; it then fires once and
    // wraps instead of running on to 2^32.
    assign tick_now = (state_reg == ST_RUNNING) && (tick_cnt_reg >= tick_last);

    // Next-state and datapath updates.
    always_comb begin
        state_next    = state_reg;
        lives_next    = lives_reg;
        score_next    = score_reg;
        level_next    = level_reg;
        food_cnt_next = food_cnt_reg;
        tick_cnt_next = tick_cnt_reg;
        die_cnt_next  = die_cnt_reg;

        case (state_reg)
            ST_INITIAL: begin
                tick_cnt_next = '0;
                die_cnt_next  = '0;
                if (any_dir) begin
                    state_next = ST_RUNNING;
                end
            end

            ST_RUNNING: begin
                tick_cnt_next = tick_now ? 32'd0 : tick_cnt_reg + 32'd1;
                if (hit) begin
                    // A collision outranks food and pause in the same cycle.
                    state_next    = ST_DIE;
                    lives_next    = (lives_reg != 4'd0) ? lives_reg - 4'd1 : 4'd0;
                    tick_cnt_next = '0;
                    die_cnt_next  = '0;
                end else begin
                    if (gc.food_eaten) begin
                        if (score_reg != SCORE_MAX) begin
                            score_next = score_reg + SCORE_ONE;
                        end
                        if ((food_cnt_reg + 32'd1) >= FOOD_LVL) begin
                            food_cnt_next = '0;
                            if (level_reg < MAX_LVL) begin
                                level_next = level_reg + 3'd1;
                            end
                        end else begin
                            food_cnt_next = food_cnt_reg + 32'd1;
                        end
                    end
                    if (pause_rise) begin
                        state_next = ST_PAUSED;
                        // Freeze the count where it is so the remaining part
                        // of the step is honoured after resume. If this very
                        // cycle ticked, the wrap to 0 stands.
                        if (!tick_now) begin
                            tick_cnt_next = tick_cnt_reg;
                        end
                    end
                end
            end

            ST_PAUSED: begin
                // Everything except a new pause press is ignored here; the
                // tick counter keeps its value.
                if (pause_rise) begin
                    state_next = ST_RUNNING;
                end
            end

            ST_DIE: begin
                tick_cnt_next = '0;
                if (die_cnt_reg >= DIE_LAST) begin
                    die_cnt_next = '0;
                    state_next   = (lives_reg != 4'd0) ? ST_INITIAL : ST_GAME_OVER;
                end else begin
                    die_cnt_next = die_cnt_reg + 32'd1;
                end
            end

            ST_GAME_OVER: begin
                tick_cnt_next = '0;
                die_cnt_next  = '0;
                // Start a fresh game but land in INITIAL, so the same press
                // does not also launch the snake.
                if (any_dir) begin
                    state_next    = ST_INITIAL;
                    lives_next    = LIVES_INIT;
                    score_next    = '0;
                    level_next    = '0;
                    food_cnt_next = '0;
                end
            end

            default: begin
                state_next    = ST_INITIAL;
                tick_cnt_next = '0;
                die_cnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_INITIAL;
            lives_reg    <= LIVES_INIT;
            score_reg    <= '0;
            level_reg    <= '0;
            food_cnt_reg <= '0;
            tick_cnt_reg <= '0;
            die_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            lives_reg    <= lives_next;
            score_reg    <= score_next;
            level_reg    <= level_next;
            food_cnt_reg <= food_cnt_next;
            tick_cnt_reg <= tick_cnt_next;
            die_cnt_reg  <= die_cnt_next;
        end
        // Tracking the live pause level through reset primes the detector,
        // so a button already held at reset is not seen as a new press.
        pause_prev_reg <= gc.pause;
    end

    assign gc.game_state = state_reg;
    assign gc.lives_left = lives_reg;
    assign gc.score      = score_reg;
    assign gc.level      = level_reg;
    assign gc.move_tick  = tick_now;

endmodule

// File: tb/tb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl
//
// Self-checking bench for game_ctrl with small parameters (DIE_CYCLES=4,
// LIVES=2, BASE_PERIOD=8, PERIOD_STEP=2, MIN_PERIOD=4, FOOD_PER_LEVEL=2,
// MAX_LEVEL=3). Each scenario task drives one cycle of stimulus, pushes the
// expected post-edge outputs onto a scoreboard queue, and pops/compares them
// one time unit after the clock edge.
// ---------------------------------------------------------------------------
module tb_game_ctrl;

    localparam int unsigned SW = 16;

    localparam int S_RUN   = 0;
    localparam int S_DIE   = 1;
    localparam int S_INIT  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_OVER  = 4;

    typedef struct packed {
        logic [2:0]    st;
        logic [3:0]    lives;
        logic [SW-1:0] score;
        logic [2:0]    lvl;
        logic          tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    game_ctrl_if #(.SCORE_W(SW)) gif();

    game_ctrl #(
        .DIE_CYCLES    (4),
        .LIVES         (2),
        .SCORE_W       (SW),
        .BASE_PERIOD   (8),
        .PERIOD_STEP   (2),
        .MIN_PERIOD    (4),
        .FOOD_PER_LEVEL(2),
        .MAX_LEVEL     (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gc (gif.slave)
    );

    function automatic exp_t mk(int st, int lives, int score, int lvl, int tick);
        exp_t r;
        r.st    = 3'(st);
        r.lives = 4'(lives);
        r.score = SW'(score);
        r.lvl   = 3'(lvl);
        r.tick  = (tick != 0);
        return r;
    endfunction

    function automatic exp_t observe();
        exp_t r;
        r.st    = gif.game_state;
        r.lives = gif.lives_left;
        r.score = gif.score;
        r.lvl   = gif.level;
        r.tick  = gif.move_tick;
        return r;
    endfunction

    function automatic string fmt(exp_t v);
        return $sformatf("st=%0d lives=%0d score=%0d lvl=%0d tick=%0d",
                         v.st, v.lives, v.score, v.lvl, v.tick);
    endfunction

    // dir bits: [3]=up [2]=down [1]=left [0]=right
    task automatic drive(input int r, input int dir, input int p,
                         input int hb, input int hs, input int fd);
        rst              = (r != 0);
        gif.up           = dir[3];
        gif.down         = dir[2];
        gif.left         = dir[1];
        gif.right        = dir[0];
        gif.pause        = (p != 0);
        gif.hit_boundary = (hb != 0);
        gif.hit_self     = (hs != 0);
        gif.food_eaten   = (fd != 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset values, reset priority over directions/hits, pause priming.
    task automatic test_reset();
        exp_t e, obs;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(1, 0, 1, 0, 0, 0);
                1:       drive(0, 0, 1, 0, 0, 0);
                2:       drive(1, 1, 0, 1, 1, 1);
                default: drive(0, 0, 0, 0, 0, 0);
            endcase
            exp_q.push_back(mk(S_INIT, 2, 0, 0, 0));
            cycle();
            obs = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL reset[%0d] got %s want %s", i, fmt(obs), fmt(e));
            else begin n_pass++; $display("reset[%0d] %s", i, fmt(obs)); end
        end
    endtask

    // Start from INITIAL with a direction, then ticks every 8 cycles.
    task automatic test_start_tick();
        exp_t e, obs;
        for (int i = 0; i < 18; i++) begin
            if (i == 0) begin
                drive(1, 0, 0, 0, 0, 0);
                exp_q.push_back(mk(S_INIT, 2, 0, 0, 0));
            end else if (i == 1) begin
                drive(0, 1, 0, 0, 0, 0);
                exp_q.push_back(mk(S_RUN, 2, 0, 0, 0));
            end else begin
                drive(0, 0, 0, 0, 0, 0);
                exp_q.push_back(mk(S_RUN, 2, 0, 0, (((i - 1) % 8) == 7) ? 1 : 0));
            end
            cycle();
            obs = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL start_tick[%0d] got %s want %s", i, fmt(obs), fmt(e));
            else begin n_pass++; $display("start_tick[%0d] %s", i, fmt(obs)); end
        end
    endtask

    // Food, score, level-up, shorter tick period, period floor, level cap.
    task automatic test_food_level();
        exp_t        e, obs;
        logic [18:0] fmask = 19'b1100000110000011110;
        logic [18:0] tmask = 19'b0010001000100010000;
        int          lv_tab[19];
        int          sc;
        lv_tab = '{0,0,1,1,2,2,2,2,2,2,2,3,3,3,3,3,3,3,3};
        sc = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                drive(1, 0, 0, 0, 0, 0);
                exp_q.push_back(mk(S_INIT, 2, 0, 0, 0));
            end else begin
                if (i == 1) drive(0, 1, 0, 0, 0, 0);
                else        drive(0, 0, 0, 0, 0, fmask[i-1] ? 1 : 0);
                if (fmask[i-1]) sc++;
                exp_q.push_back(mk(S_RUN, 2, sc, lv_tab[i-1], tmask[i-1] ? 1 : 0));
            end
            cycle();
            obs = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL food_level[%0d] got %s want %s", i, fmt(obs), fmt(e));
            else begin n_pass++; $display("food_level[%0d] %s", i, fmt(obs)); end
        end
    endtask

    // Two deaths: DIE timing, lives, score kept, GAME_OVER, restart.
    task automatic test_die_game_over();
        exp_t e, obs;
        int   s;
        for (int i = 0; i < 18; i++) begin
            s = i - 1;
            case (s)
                -1:      begin drive(1, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_INIT, 2, 0, 0, 0)); end
                0:       begin drive(0, 1, 0, 0, 0, 0); exp_q.push_back(mk(S_RUN,  2, 0, 0, 0)); end
                1:       begin drive(0, 0, 0, 0, 0, 1); exp_q.push_back(mk(S_RUN,  2, 1, 0, 0)); end
                2, 3:    begin drive(0, 0, 0, 0, 1, 0); exp_q.push_back(mk(S_DIE,  1, 1, 0, 0)); end
                4, 5:    begin drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_DIE,  1, 1, 0, 0)); end
                6, 7:    begin drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_INIT, 1, 1, 0, 0)); end
                8:       begin drive(0, 8, 0, 0, 0, 0); exp_q.push_back(mk(S_RUN,  1, 1, 0, 0)); end
                9:       begin drive(0, 0, 0, 1, 1, 1); exp_q.push_back(mk(S_DIE,  0, 1, 0, 0)); end
                10, 11, 12:
                         begin drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_DIE,  0, 1, 0, 0)); end
                13, 14:  begin drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_OVER, 0, 1, 0, 0)); end
                15:      begin drive(0, 2, 0, 0, 0, 0); exp_q.push_back(mk(S_INIT, 2, 0, 0, 0)); end
                default: begin drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_INIT, 2, 0, 0, 0)); end
            endcase
            cycle();
            obs = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL die_over[%0d] got %s want %s", i, fmt(obs), fmt(e));
            else begin n_pass++; $display("die_over[%0d] %s", i, fmt(obs)); end
        end
    endtask

    // Pause ignored in INITIAL, pause at count 5, inputs ignored while paused,
    // resume ticks 3 cycles later, reset while paused leaves no residual count.
    task automatic test_pause();
        exp_t e, obs;
        int   p;
        for (int i = 0; i < 44; i++) begin
            p = i - 1;
            if (p < 0) begin
                drive(1, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_INIT, 2, 0, 0, 0));
            end else if (p == 0) begin
                drive(0, 0, 1, 0, 0, 0); exp_q.push_back(mk(S_INIT, 2, 0, 0, 0));
            end else if (p == 1) begin
                drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_INIT, 2, 0, 0, 0));
            end else if (p == 2) begin
                drive(0, 1, 0, 0, 0, 0); exp_q.push_back(mk(S_RUN, 2, 0, 0, 0));
            end else if (p <= 7) begin
                drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_RUN, 2, 0, 0, 0));
            end else if (p <= 10) begin
                drive(0, 0, 1, 0, 0, 0); exp_q.push_back(mk(S_PAUSE, 2, 0, 0, 0));
            end else if (p <= 15) begin
                drive(0, 8, 0, 1, 1, 1); exp_q.push_back(mk(S_PAUSE, 2, 0, 0, 0));
            end else if (p <= 27) begin
                drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_PAUSE, 2, 0, 0, 0));
            end else if (p <= 29) begin
                drive(0, 0, 1, 0, 0, 0); exp_q.push_back(mk(S_RUN, 2, 0, 0, 0));
            end else if (p == 30) begin
                drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_RUN, 2, 0, 0, 1));
            end else if (p == 31) begin
                drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_RUN, 2, 0, 0, 0));
            end else if (p == 32) begin
                drive(0, 0, 1, 0, 0, 0); exp_q.push_back(mk(S_PAUSE, 2, 0, 0, 0));
            end else if (p == 33) begin
                drive(1, 0, 1, 0, 0, 0); exp_q.push_back(mk(S_INIT, 2, 0, 0, 0));
            end else if (p == 34) begin
                drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_INIT, 2, 0, 0, 0));
            end else if (p == 35) begin
                drive(0, 1, 0, 0, 0, 0); exp_q.push_back(mk(S_RUN, 2, 0, 0, 0));
            end else begin
                drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_RUN, 2, 0, 0, (p == 42) ? 1 : 0));
            end
            cycle();
            obs = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL pause[%0d] got %s want %s", i, fmt(obs), fmt(e));
            else begin n_pass++; $display("pause[%0d] %s", i, fmt(obs)); end
        end
    endtask

    // Hit + food + pause edge in one cycle: the hit wins.
    task automatic test_same_cycle();
        exp_t e, obs;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       begin drive(1, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_INIT, 2, 0, 0, 0)); end
                1:       begin drive(0, 1, 0, 0, 0, 0); exp_q.push_back(mk(S_RUN,  2, 0, 0, 0)); end
                2:       begin drive(0, 0, 0, 0, 0, 1); exp_q.push_back(mk(S_RUN,  2, 1, 0, 0)); end
                3:       begin drive(0, 0, 1, 1, 0, 1); exp_q.push_back(mk(S_DIE,  1, 1, 0, 0)); end
                default: begin drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_DIE,  1, 1, 0, 0)); end
            endcase
            cycle();
            obs = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL same_cycle[%0d] got %s want %s", i, fmt(obs), fmt(e));
            else begin n_pass++; $display("same_cycle[%0d] %s", i, fmt(obs)); end
        end
    endtask

    // Reset in the middle of DIE, then a clean restart with a full period.
    task automatic test_rst_mid_die();
        exp_t e, obs;
        int   s;
        for (int i = 0; i < 19; i++) begin
            s = i - 1;
            if (s < 0) begin
                drive(1, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_INIT, 2, 0, 0, 0));
            end else if (s == 0) begin
                drive(0, 1, 0, 0, 0, 0); exp_q.push_back(mk(S_RUN, 2, 0, 0, 0));
            end else if (s == 1) begin
                drive(0, 0, 0, 0, 0, 1); exp_q.push_back(mk(S_RUN, 2, 1, 0, 0));
            end else if (s == 2) begin
                drive(0, 0, 0, 0, 1, 0); exp_q.push_back(mk(S_DIE, 1, 1, 0, 0));
            end else if (s <= 4) begin
                drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_DIE, 1, 1, 0, 0));
            end else if (s == 5) begin
                drive(1, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_INIT, 2, 0, 0, 0));
            end else if (s <= 9) begin
                drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_INIT, 2, 0, 0, 0));
            end else if (s == 10) begin
                drive(0, 4, 0, 0, 0, 0); exp_q.push_back(mk(S_RUN, 2, 0, 0, 0));
            end else begin
                drive(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(S_RUN, 2, 0, 0, (s == 17) ? 1 : 0));
            end
            cycle();
            obs = observe();
            e   = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL rst_mid_die[%0d] got %s want %s", i, fmt(obs), fmt(e));
            else begin n_pass++; $display("rst_mid_die[%0d] %s", i, fmt(obs)); end
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        test_reset();
        test_start_tick();
        test_food_level();
        test_die_game_over();
        test_pause();
        test_same_cycle();
        test_rst_mid_die();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
